// File: rtl/alu_seq.sv
// alu_seq: handshaked N-bit ALU with single-cycle logic/arith ops and an N-step shift-add multiplier
// Ports: clk, rst_n (sync, active-low); A, B, Cin, Mode, in_valid -> in_ready (request side);
//        Y, Cout, Overflow, out_valid <- out_ready (registered result side).
module alu_seq #(
  parameter int N          = 16,
  parameter int MUL_CYCLES = N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [3:0]   Mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] Y,
  output logic         Cout,
  output logic         Overflow,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int LW = $clog2(N);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] prod_q, prod_d, step;
  logic [N-1:0] a_q, a_d, y_q, y_d, alu_y, bop;
  logic [LW-1:0] cnt_q, cnt_d;
  logic hi_q, hi_d, cout_q, cout_d, ovf_q, ovf_d, alu_c, alu_v;
  logic [N:0] sum, psum;
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = state_q == DONE;
  assign Y         = y_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  // Product register holds {partial high half, remaining multiplier bits}; add multiplicand on LSB, then shift right.
  assign psum = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign step = {psum, prod_q[N-1:1]};
  always_comb begin
    bop   = Mode[0] ? ~B : B;
    sum   = {1'b0, A} + {1'b0, bop} + {{N{1'b0}}, Cin};
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (Mode)
      4'b0000: alu_y = A & B;
      4'b0001: alu_y = A | B;
      4'b0010: alu_y = A ^ B;
      4'b0011: alu_y = ~A;
      4'b0100, 4'b0101: begin
        alu_y = sum[N-1:0];
        alu_c = sum[N];
        alu_v = (A[N-1] == bop[N-1]) && (sum[N-1] != A[N-1]);
      end
      4'b0110: alu_y = A << B[LW-1:0];
      4'b0111: alu_y = $signed(A) >>> B[LW-1:0];
      4'b1000: alu_y = {{(N-1){1'b0}}, $signed(A) < $signed(B)};
      4'b1001: alu_y = {{(N-1){1'b0}}, A < B};
      default: alu_y = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    hi_d    = hi_q;
    y_d     = y_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && in_valid) begin
      if (Mode[3:1] == 3'b101) begin
        state_d = MUL;
        prod_d  = {{N{1'b0}}, B};
        cnt_d   = '0;
        a_d     = A;
        hi_d    = Mode[0];
      end else begin
        state_d = DONE;
        y_d     = alu_y;
        cout_d  = alu_c;
        ovf_d   = alu_v;
      end
    end else if (state_q == MUL) begin
      prod_d = step;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LW'(MUL_CYCLES - 1)) begin
        state_d = DONE;
        y_d     = hi_q ? step[2*N-1:N] : step[N-1:0];
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prod_q  <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, Cin = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [3:0] Mode = '0;
  logic in_ready, Cout, Overflow, out_valid;
  logic [15:0] Y;
  int checks = 0, errors = 0;

  alu_seq #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .Mode(Mode),
    .in_valid(in_valid), .in_ready(in_ready), .Y(Y), .Cout(Cout),
    .Overflow(Overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] m, input logic [15:0] a, b, input logic c,
                                output logic [15:0] y, output logic co, ov);
    logic [15:0] bb;
    logic [16:0] u;
    logic [31:0] p;
    int s;
    co = 1'b0;
    ov = 1'b0;
    p = {16'b0, a} * {16'b0, b};
    bb = m[0] ? ~b : b;
    u = {1'b0, a} + {1'b0, bb} + {16'b0, c};
    s = int'($signed(a)) + int'($signed(bb)) + int'(c);
    case (m)
      4'd0: y = a & b;
      4'd1: y = a | b;
      4'd2: y = a ^ b;
      4'd3: y = ~a;
      4'd4, 4'd5: begin y = u[15:0]; co = u[16]; ov = (s > 32767) || (s < -32768); end
      4'd6: y = a << b[3:0];
      4'd7: y = $signed(a) >>> b[3:0];
      4'd8: y = (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
      4'd9: y = (a < b) ? 16'd1 : 16'd0;
      4'd10: y = p[15:0];
      4'd11: y = p[31:16];
      default: y = 16'd0;
    endcase
  endfunction

  task automatic send(input logic [3:0] m, input logic [15:0] a, b, input logic c);
    @(negedge clk);
    Mode = m; A = a; B = b; Cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Mode = 4'($urandom); Cin = 1'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; Mode = 4'd0; A = 16'hFFFF; B = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({Y, Cout, Overflow} !== 18'd0) begin errors++; $display("FAIL reset_result got %h/%b/%b exp 0", Y, Cout, Overflow); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || Y !== 16'hFFFF) begin errors++; $display("FAIL first_accept got ov=%b Y=%h exp 1/FFFF", out_valid, Y); end
    take();
  endtask

  task automatic test_directed;
    logic [3:0] m[4] = '{4'd4, 4'd5, 4'd5, 4'd13};
    logic [15:0] a[4] = '{16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF};
    logic [15:0] b[4] = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
    logic c[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] ey[4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
    logic ec[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic ev[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(m[i], a[i], b[i], c[i]);
      wait_out(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL directed%0d_latency got %0d exp 1", i, lat); end
      checks++; if ({Y, Cout, Overflow} !== {ey[i], ec[i], ev[i]}) begin errors++; $display("FAIL directed%0d got Y=%h C=%b V=%b exp Y=%h C=%b V=%b", i, Y, Cout, Overflow, ey[i], ec[i], ev[i]); end
      take();
    end
  endtask

  task automatic test_mul;
    logic [15:0] ey[2] = '{16'h2340, 16'h0001};
    int lat;
    for (int i = 0; i < 2; i++) begin
      send(4'd10 + 4'(i), 16'h1234, 16'h0010, 1'b1);
      wait_out(lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL mul%0d_latency got %0d exp 17", i, lat); end
      checks++; if ({Y, Cout, Overflow} !== {ey[i], 2'b00}) begin errors++; $display("FAIL mul%0d got Y=%h C=%b V=%b exp Y=%h C=0 V=0", i, Y, Cout, Overflow, ey[i]); end
      take();
    end
  endtask

  task automatic test_hold;
    int lat;
    send(4'd7, 16'h8000, 16'hFFF4, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (Y !== 16'hF800 || out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d got Y=%h ov=%b ir=%b exp F800/1/0", i, Y, out_valid, in_ready); end
      @(posedge clk); #1;
    end
    take();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
    checks++; if (Y !== 16'hF800) begin errors++; $display("FAIL idle_keeps_y got %h exp F800", Y); end
  endtask

  task automatic test_abort;
    int lat;
    send(4'd10, 16'h1234, 16'h0010, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || Y !== 16'h0000) begin errors++; $display("FAIL abort got ov=%b Y=%h exp 0/0000", out_valid, Y); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b exp 1", in_ready); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result got ov=%b exp 0", out_valid); end
    send(4'd0, 16'hF0F0, 16'hFF00, 1'b0);
    wait_out(lat);
    checks++; if (lat !== 1 || Y !== 16'hF000) begin errors++; $display("FAIL after_abort got lat=%0d Y=%h exp 1/F000", lat, Y); end
    take();
  endtask

  task automatic test_back_to_back;
    logic [15:0] a1, b1, a2, b2;
    a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
    send(4'd2, a1, b1, 1'b0);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; Mode = 4'd1; A = a2; B = b2;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Y !== (a1 ^ b1)) begin errors++; $display("FAIL b2b_gap got ov=%b ir=%b Y=%h exp 0/1/%h", out_valid, in_ready, Y, a1 ^ b1); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || Y !== (a2 | b2)) begin errors++; $display("FAIL b2b_second got ov=%b Y=%h exp 1/%h", out_valid, Y, a2 | b2); end
    take();
  endtask

  task automatic test_random;
    logic [3:0] m;
    logic [15:0] a, b, ey;
    logic c, ec, ev;
    int lat, hold;
    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom_range(0, 15));
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      if (i % 5 == 0) a = 16'h8000 | 16'($urandom_range(0, 3));
      model(m, a, b, c, ey, ec, ev);
      send(m, a, b, c);
      in_valid = 1'b1;
      wait_out(lat);
      checks++; if (lat !== ((m == 4'd10 || m == 4'd11) ? 17 : 1)) begin errors++; $display("FAIL rand%0d_latency mode=%h got %0d", i, m, lat); end
      hold = $urandom_range(0, 2);
      for (int k = 0; k <= hold; k++) begin
        checks++; if ({Y, Cout, Overflow} !== {ey, ec, ev}) begin errors++; $display("FAIL rand%0d mode=%h A=%h B=%h Cin=%b got Y=%h C=%b V=%b exp Y=%h C=%b V=%b", i, m, a, b, c, Y, Cout, Overflow, ey, ec, ev); end
        if (k < hold) begin @(posedge clk); #1; end
      end
      take();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_release got ov=%b exp 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_hold();
    test_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
